// File: rtl/gate_sweep_ctrl.sv
// Sweeps every input vector into a gate-under-test, samples its output after a settle
// time and checks the truth table. Define GATE_SWEEP_ABORT_EN to stop at the first mismatch.
module gate_sweep_ctrl #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 2,
  localparam int V     = 1 << N_IN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [V-1:0]    expected,
  output logic [N_IN-1:0] gate_in,
  input  logic            gate_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [V-1:0]    truth,
  output logic [N_IN:0]   err_count
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [N_IN-1:0] r_idx, w_idx_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [V-1:0]    r_exp, w_exp_nxt;
  logic [N_IN-1:0] r_gate_in, w_gate_in_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic            r_pass, w_pass_nxt;
  logic [V-1:0]    r_truth, w_truth_nxt;
  logic [N_IN:0]   r_err, w_err_nxt;
  logic            w_mis;
  logic            w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_exp     <= '0;
      r_gate_in <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_truth   <= '0;
      r_err     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_cnt     <= w_cnt_nxt;
      r_exp     <= w_exp_nxt;
      r_gate_in <= w_gate_in_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_pass    <= w_pass_nxt;
      r_truth   <= w_truth_nxt;
      r_err     <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_cnt_nxt     = r_cnt;
    w_exp_nxt     = r_exp;
    w_gate_in_nxt = r_gate_in;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_pass_nxt    = r_pass;
    w_truth_nxt   = r_truth;
    w_err_nxt     = r_err;
    w_mis         = 1'b0;
    w_last        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_exp_nxt     = expected;
          w_truth_nxt   = '0;
          w_err_nxt     = '0;
          w_pass_nxt    = 1'b0;
          w_idx_nxt     = '0;
          w_gate_in_nxt = '0;
          w_cnt_nxt     = '0;
          w_busy_nxt    = 1'b1;
          w_state_nxt   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_state_nxt = S_SAMPLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_SAMPLE: begin
        w_truth_nxt[r_idx] = gate_out;
        w_mis              = (gate_out != r_exp[r_idx]);
        if (w_mis) begin
          w_err_nxt = r_err + 1'b1;
        end
`ifdef GATE_SWEEP_ABORT_EN
        w_last = w_mis || (r_idx == '1);
`else
        w_last = (r_idx == '1);
`endif
        if (w_last) begin
          // done is registered on entry so its pulse coincides with the DONE state
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt     = r_idx + 1'b1;
          w_gate_in_nxt = r_idx + 1'b1;
          w_cnt_nxt     = '0;
          w_state_nxt   = S_SETTLE;
        end
      end
      S_DONE: begin
        w_pass_nxt  = (r_err == '0);
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign gate_in   = r_gate_in;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign truth     = r_truth;
  assign err_count = r_err;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl: table of gate/expected sweeps plus reset and
// small-configuration sequences. Expectations follow GATE_SWEEP_ABORT_EN when defined.
module tb_gate_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] expected;
  logic [1:0] gate_in;
  logic       gate_out;
  logic       busy, done, pass;
  logic [3:0] truth;
  logic [2:0] err_count;

  logic       start_b;
  logic [1:0] expected_b;
  logic [0:0] gate_in_b;
  logic       gate_out_b;
  logic       busy_b, done_b, pass_b;
  logic [1:0] truth_b;
  logic [1:0] err_b;

  int gut;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .expected(expected), .gate_in(gate_in),
    .gate_out(gate_out), .busy(busy), .done(done), .pass(pass), .truth(truth),
    .err_count(err_count)
  );

  gate_sweep_ctrl #(.N_IN(1), .SETTLE(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .expected(expected_b), .gate_in(gate_in_b),
    .gate_out(gate_out_b), .busy(busy_b), .done(done_b), .pass(pass_b), .truth(truth_b),
    .err_count(err_b)
  );

  // gate models: 0 NAND, 1 AND, 2 OR, 3 XOR; gate_in[1]=a, gate_in[0]=b
  always_comb begin
    gate_out = 1'b0;
    case (gut)
      0: gate_out = ~(gate_in[1] & gate_in[0]);
      1: gate_out = gate_in[1] & gate_in[0];
      2: gate_out = gate_in[1] | gate_in[0];
      3: gate_out = gate_in[1] ^ gate_in[0];
      default: gate_out = 1'b0;
    endcase
  end
  assign gate_out_b = ~gate_in_b[0];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         gut;
    logic [3:0] exp;
    int         restart;
    bit         start_in_done;
    logic [3:0] truth;
    int         err;
    bit         pass;
    int         lat;
  } vec_t;

  vec_t tbl[6];

  task automatic run_sweep(input vec_t v);
    int cyc;
    int seq_bad;
    int dones;
    seq_bad  = 0;
    dones    = 0;
    gut      = v.gut;
    expected = v.exp;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    chk("clear_truth", truth, 0);
    chk("clear_err", err_count, 0);
    chk("clear_pass", pass, 0);
    while (!done && cyc < 200) begin
      if (int'(gate_in) != (cyc - 1) / 3) seq_bad++;
      if (busy !== 1'b1) seq_bad++;
      if (cyc == v.restart) begin
        start    = 1'b1;
        expected = 4'b0000;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("latency", cyc, v.lat);
    chk("gate_in_busy_seq", seq_bad, 0);
    chk("busy_at_done", busy, 0);
    chk("truth", truth, v.truth);
    chk("err_count", err_count, v.err);
    if (done) dones++;
    if (v.start_in_done) start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    expected = v.exp;
    if (done) dones++;
    chk("done_pulses", dones, 1);
    chk("pass", pass, v.pass);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int cyc;
    int dones;
    tbl[0] = '{gut: 0, exp: 4'b0111, restart: 0, start_in_done: 1'b1,
               truth: 4'b0111, err: 0, pass: 1'b1, lat: 13};
`ifdef GATE_SWEEP_ABORT_EN
    tbl[1] = '{gut: 1, exp: 4'b0111, restart: 0, start_in_done: 1'b0,
               truth: 4'b0000, err: 1, pass: 1'b0, lat: 4};
    tbl[3] = '{gut: 3, exp: 4'b0111, restart: 0, start_in_done: 1'b0,
               truth: 4'b0000, err: 1, pass: 1'b0, lat: 4};
    tbl[4] = '{gut: 2, exp: 4'b0000, restart: 0, start_in_done: 1'b0,
               truth: 4'b0010, err: 1, pass: 1'b0, lat: 7};
`else
    tbl[1] = '{gut: 1, exp: 4'b0111, restart: 0, start_in_done: 1'b0,
               truth: 4'b1000, err: 4, pass: 1'b0, lat: 13};
    tbl[3] = '{gut: 3, exp: 4'b0111, restart: 0, start_in_done: 1'b0,
               truth: 4'b0110, err: 1, pass: 1'b0, lat: 13};
    tbl[4] = '{gut: 2, exp: 4'b0000, restart: 0, start_in_done: 1'b0,
               truth: 4'b1110, err: 3, pass: 1'b0, lat: 13};
`endif
    tbl[2] = '{gut: 2, exp: 4'b1110, restart: 0, start_in_done: 1'b0,
               truth: 4'b1110, err: 0, pass: 1'b1, lat: 13};
    tbl[5] = '{gut: 0, exp: 4'b0111, restart: 5, start_in_done: 1'b0,
               truth: 4'b0111, err: 0, pass: 1'b1, lat: 13};

    rst        = 1'b1;
    start      = 1'b0;
    expected   = '0;
    start_b    = 1'b0;
    expected_b = '0;
    gut        = 0;
    #12;
    chk("rst_gate_in", gate_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_truth", truth, 0);
    chk("rst_err", err_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_sweep(tbl[i]);

    // reset during the third settle window
    gut      = 0;
    expected = 4'b0111;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_rst_gate_in", gate_in, 2);
    chk("pre_rst_truth", truth, 4'b0011);
    #2 rst = 1'b1;
    #1;
    chk("midrst_gate_in", gate_in, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pass", pass, 0);
    chk("midrst_truth", truth, 0);
    chk("midrst_err", err_count, 0);
    @(posedge clk); #1;
    rst   = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    chk("no_done_after_rst", dones, 0);
    run_sweep(tbl[0]);

    // one-input, one-cycle-settle instance with an inverter
    expected_b = 2'b01;
    start_b    = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    cyc     = 1;
    while (!done_b && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("b_latency", cyc, 5);
    chk("b_truth", truth_b, 2'b01);
    chk("b_err", err_b, 0);
    @(posedge clk); #1;
    chk("b_pass", pass_b, 1);
    chk("b_done_clear", done_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
